d_mem_ctrl: RTL and testbench
=============================

// Module: d_mem_ctrl
// PURPOSE
//  Data memory with handshake, the successor of the plain single-cycle RAM for the multicycle datapath.
//  - Serves lb/lbu/lh/lhu/lw and sb/sh/sw over a valid/ready request port with configurable wait states.
//  - Byte-lane stores; sign- or zero-extended loads.
//  - Misaligned and out-of-range accesses are reported as errors instead of corrupting memory.
// PARAMETERS
//  MAX_SIZE      128  number of 32-bit words in the array
//  ADDRESS_SIZE  32   byte-address width
//  DATA_SIZE     32   data width; only 32 is legal (elaboration error otherwise)
//  WAIT_STATES   0    extra cycles between accept and access, 0..15
// PORTS
//  clk             in   1   clock; all state updates on the rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  req_valid       in   1   request present
//  req_ready       out  1   block can accept a request this cycle
//  req_write       in   1   1 = store, 0 = load
//  req_size        in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned    in   1   loads: 1 = zero-extend, 0 = sign-extend
//  address         in   ADDRESS_SIZE  byte address
//  writeData       in   DATA_SIZE     store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid      out  1   one-cycle pulse: access completed
//  readData        out  DATA_SIZE     load result; held until the next response
//  resp_err        out  1   valid with resp_valid: access rejected
//  resp_err_code   out  2   01 misaligned, 10 out of range, 11 reserved size, 00 none
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, wait counter 0.
//   - Outputs: req_ready=1 once released, resp_valid=0, readData=0, resp_err=0, resp_err_code=00.
//   - Array contents are not reset; they are zeroed only at time 0.
//  Accept: a request is accepted at edge k when req_valid && req_ready. All request fields latch at k.
//  FSM IDLE/BUSY. req_ready = (state==IDLE).
//   - WAIT_STATES=0: access at edge k, state stays IDLE, 1 request/cycle back-to-back.
//   - WAIT_STATES=N>0: k -> BUSY with counter=N.
//     - Counter decrements each edge; access at edge k+N, same edge BUSY -> IDLE.
//     - req_ready is low during cycles k+1..k+N.
//  Response: resp_valid=1 for exactly the cycle after the access edge, with readData/resp_err valid.
//   - No backpressure on the response side.
//  Word index = address[ADDRESS_SIZE-1:2]. Lanes are little-endian: byte lane = address[1:0].
//  Error check, in priority order:
//   - size 11 -> code 11;
//   - half with address[0]=1, or word with address[1:0]!=0 -> code 01;
//   - index >= MAX_SIZE -> code 10.
//   On error: no array write, readData=0, resp_err=1.
//  Store: write enables only the addressed lanes (sb 1 lane, sh lanes {a1,0}/{a1,1}, sw all 4).
//   Other bytes are preserved.
//  Load: select the lane(s), then extend to 32 bits per req_unsigned. req_unsigned is ignored for word.
//  Load after store to the same word, next request: returns the new data (read sees the committed array).
//  Reset mid-operation (BUSY): the pending request is dropped, no write occurs, and no response is issued.
//  req_valid while BUSY: ignored; the master must hold the request.
// STRUCTURE
//  mem_pkg:
//   - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
//   - error codes ERR_NONE/ERR_ALIGN/ERR_RANGE/ERR_SIZE;
//   - FSM state typedef.
//  Sub-module byte_lane_ram: MAX_SIZE x 4 byte-enabled array.
//   - Synchronous write with 4-bit enable, asynchronous read.
//   - Zero-initialised.
//  Top: FSM, wait counter, error check, lane mux/extend, response registers.
// TESTING
//  1 sw 0xDEADBEEF @0x10, then lw @0x10 (W=0) -> resp_valid the cycle after each accept; readData=0xDEADBEEF.
//  2 sb 0x7F @0x11, then lb @0x11 -> 0x0000007F. lbu @0x13 -> 0x000000DE. lb @0x13 -> 0xFFFFFFDE.
//    lw @0x10 -> 0xDEAD7FEF.
//  3 lh @0x12 -> 0xFFFFDEAD. lhu @0x12 -> 0x0000DEAD.
//    lh @0x11 -> resp_err=1, code 01, readData=0.
//    sw @0x02 -> code 01, memory unchanged.
//  4 (MAX_SIZE=128) sw @0x200 -> code 10, no write. size=11 -> code 11.
//  5 WAIT_STATES=3: accept at edge k -> req_ready low cycles k+1..k+3, resp_valid cycle after edge k+3.
//    Back-to-back W=0 sw/lw stream gives one response per cycle.
//  6 Assert rst_n=0 mid-BUSY on a store -> no response; word unchanged; outputs at reset values immediately.

Source files
------------

// File: rtl/d_mem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: access sizes, error codes,
// FSM state type and the store lane-mask helper.
package d_mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_SIZE  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Byte lanes touched by an access of the given size at byte offset lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_ctrl_if.sv
// Request/response bus between a load/store master and d_mem_ctrl.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the master holds
// every req_* field stable until then. resp_valid is a one-cycle pulse with no backpressure.
interface d_mem_ctrl_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDRESS_SIZE-1:0] address;
  logic [DATA_SIZE-1:0]    writeData;
  logic                    resp_valid;
  logic [DATA_SIZE-1:0]    readData;
  logic                    resp_err;
  logic [1:0]              resp_err_code;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, writeData,
    input  req_ready, resp_valid, readData, resp_err, resp_err_code
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, writeData,
    output req_ready, resp_valid, readData, resp_err, resp_err_code
  );
endinterface

// File: rtl/d_mem_ctrl_byte_lane_ram.sv
// MAX_SIZE x 32-bit array with per-byte write enables, synchronous write and
// asynchronous read; contents start at zero and are never reset.
module byte_lane_ram #(
  parameter int MAX_SIZE = 128,
  parameter int IDX_W    = 7
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MAX_SIZE] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/d_mem_ctrl.sv
// Handshaked data memory for the multicycle datapath: byte/half/word loads and
// stores with optional wait states and error responses for illegal accesses.
module d_mem_ctrl
  import d_mem_ctrl_pkg::*;
#(
  parameter int MAX_SIZE     = 128,
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int WAIT_STATES  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  d_mem_ctrl_if.slave bus,
  output state_t     dbg_state
);

  localparam int IDX_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam logic [ADDRESS_SIZE-3:0] IDX_LIMIT = (ADDRESS_SIZE-2)'(MAX_SIZE);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  if (DATA_SIZE != 32) begin : g_bad_data_size
    $error("d_mem_ctrl: DATA_SIZE must be 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("d_mem_ctrl: WAIT_STATES must be 0..15");
  end

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    l_write;
  logic [1:0]              l_size;
  logic                    l_uns;
  logic [ADDRESS_SIZE-1:0] l_addr;
  logic [31:0]             l_wdata;

  logic                    accept;
  logic                    access;
  logic                    a_write;
  logic [1:0]              a_size;
  logic                    a_uns;
  logic [ADDRESS_SIZE-1:0] a_addr;
  logic [31:0]             a_wdata;
  logic [ADDRESS_SIZE-3:0] word_idx;
  logic [1:0]              err_code;
  logic [3:0]              ram_we;
  logic [31:0]             ram_wdata;
  logic [31:0]             ram_rdata;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_val;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign dbg_state     = state;

  // Without wait states the access happens on the accept edge, straight from the bus.
  assign a_write = (WAIT_STATES == 0) ? bus.req_write    : l_write;
  assign a_size  = (WAIT_STATES == 0) ? bus.req_size     : l_size;
  assign a_uns   = (WAIT_STATES == 0) ? bus.req_unsigned : l_uns;
  assign a_addr  = (WAIT_STATES == 0) ? bus.address      : l_addr;
  assign a_wdata = (WAIT_STATES == 0) ? bus.writeData    : l_wdata;
  assign access  = (WAIT_STATES == 0) ? accept : (state == ST_BUSY && wait_cnt == 4'd1);

  assign word_idx = a_addr[ADDRESS_SIZE-1:2];

  always_comb begin
    err_code = ERR_NONE;
    if (a_size == SZ_RSVD) begin
      err_code = ERR_SIZE;
    end else if ((a_size == SZ_HALF && a_addr[0]) ||
                 (a_size == SZ_WORD && a_addr[1:0] != 2'b00)) begin
      err_code = ERR_ALIGN;
    end else if (word_idx >= IDX_LIMIT) begin
      err_code = ERR_RANGE;
    end
  end

  // Store data is replicated across lanes so the lane mask alone picks the target bytes.
  always_comb begin
    ram_wdata = a_wdata;
    case (a_size)
      SZ_BYTE: ram_wdata = {4{a_wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{a_wdata[15:0]}};
      default: ram_wdata = a_wdata;
    endcase
    ram_we = (access && a_write && err_code == ERR_NONE) ? lane_mask(a_size, a_addr[1:0]) : 4'b0000;
  end

  byte_lane_ram #(
    .MAX_SIZE (MAX_SIZE),
    .IDX_W    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_idx[IDX_W-1:0]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    byte_sel = ram_rdata[7:0];
    case (a_addr[1:0])
      2'd0: byte_sel = ram_rdata[7:0];
      2'd1: byte_sel = ram_rdata[15:8];
      2'd2: byte_sel = ram_rdata[23:16];
      2'd3: byte_sel = ram_rdata[31:24];
      default: byte_sel = ram_rdata[7:0];
    endcase
    half_sel = a_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (a_size)
      SZ_BYTE: load_val = {{24{~a_uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{~a_uns & half_sel[15]}}, half_sel};
      SZ_WORD: load_val = ram_rdata;
      default: load_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      wait_cnt          <= 4'd0;
      l_write           <= 1'b0;
      l_size            <= SZ_BYTE;
      l_uns             <= 1'b0;
      l_addr            <= '0;
      l_wdata           <= 32'h0;
      bus.resp_valid    <= 1'b0;
      bus.readData      <= '0;
      bus.resp_err      <= 1'b0;
      bus.resp_err_code <= ERR_NONE;
    end else begin
      if (accept) begin
        l_write <= bus.req_write;
        l_size  <= bus.req_size;
        l_uns   <= bus.req_unsigned;
        l_addr  <= bus.address;
        l_wdata <= bus.writeData;
      end
      case (state)
        ST_IDLE: begin
          if (accept && WAIT_STATES != 0) begin
            state    <= ST_BUSY;
            wait_cnt <= WAIT_INIT;
          end
        end
        ST_BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      bus.resp_valid <= access;
      if (access) begin
        bus.readData      <= (err_code != ERR_NONE || a_write) ? '0 : load_val;
        bus.resp_err      <= (err_code != ERR_NONE);
        bus.resp_err_code <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Bench for d_mem_ctrl: one instance with no wait states and one with three,
// driven through the request bus and scored against a byte-array reference model.
module tb_d_mem_ctrl;
  import d_mem_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n, rst3_n;

  d_mem_ctrl_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) if0 ();
  d_mem_ctrl_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) if3 ();
  state_t dbg0, dbg3;

  d_mem_ctrl #(.MAX_SIZE(128), .ADDRESS_SIZE(32), .DATA_SIZE(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(if0.slave), .dbg_state(dbg0));
  d_mem_ctrl #(.MAX_SIZE(128), .ADDRESS_SIZE(32), .DATA_SIZE(32), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(if3.slave), .dbg_state(dbg3));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Expected entry: {check_data, err, code[1:0], data[31:0]}
  logic [7:0]  ref_mem [2][512];
  logic [35:0] exp_q0[$];
  logic [35:0] exp_q3[$];
  int          cyc_q0[$];
  int          cyc_q3[$];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] ld(input logic [31:0] v);
    return {4'b1000, v};
  endfunction

  function automatic logic [35:0] er(input logic [1:0] code);
    return {2'b11, code, 32'h0};
  endfunction

  function automatic logic [35:0] model(input int d, input logic wr, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  code;
    logic [31:0] v;
    int          nb;
    int          ai;
    code = 2'b00;
    if (sz == 2'b11) code = 2'b11;
    else if ((sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)) code = 2'b01;
    else if (a / 4 >= 128) code = 2'b10;
    if (code != 2'b00) return er(code);
    nb = 1 << sz;
    ai = int'(a);
    if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[d][9'(ai + i)] = wd[8*i +: 8];
      return 36'h0;
    end
    v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[d][9'(ai + i)];
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
    return ld(v);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int d, input logic v, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_write = wr; if0.req_size = sz;
      if0.req_unsigned = uns; if0.address = a; if0.writeData = wd;
    end else begin
      if3.req_valid = v; if3.req_write = wr; if3.req_size = sz;
      if3.req_unsigned = uns; if3.address = a; if3.writeData = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.req_ready : if3.req_ready;
  endfunction

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge
  // with req_valid still high so calls can be chained back to back.
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit push, input bit use_const, input logic [35:0] cexp);
    logic [35:0] e;
    int waited;
    waited = 0;
    drive(d, 1'b1, wr, sz, uns, a, wd);
    while (!rdy(d) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_assert++;
    if (!rdy(d)) begin
      n_fail++;
      $display("FAIL accept_timeout: dut %0d never raised req_ready within %0d cycles", d, waited);
      idle(d);
      return;
    end
    if (push) begin
      e = model(d, wr, sz, uns, a, wd);
      if (use_const) e = cexp;
      if (d == 0) begin exp_q0.push_back(e); cyc_q0.push_back(cyc + 1); end
      else begin exp_q3.push_back(e); cyc_q3.push_back(cyc + 4); end
    end
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitors ----------------
  task automatic score(input int d, input logic err, input logic [1:0] code, input logic [31:0] data);
    logic [35:0] e;
    int t;
    if ((d == 0 && exp_q0.size() == 0) || (d != 0 && exp_q3.size() == 0)) begin
      n_assert++;
      n_fail++;
      $display("FAIL unexpected_resp: dut %0d responded with err=%0b code=%0b data=%h, required no response",
               d, err, code, data);
      return;
    end
    if (d == 0) begin e = exp_q0.pop_front(); t = cyc_q0.pop_front(); end
    else begin e = exp_q3.pop_front(); t = cyc_q3.pop_front(); end
    check(d == 0 ? "resp_dut0" : "resp_dut3", {e[35], err, code, e[35] ? data : 32'h0}, e);
    check(d == 0 ? "latency_dut0" : "latency_dut3", 36'(cyc), 36'(t));
  endtask

  always @(negedge clk) if (if0.resp_valid === 1'b1) score(0, if0.resp_err, if0.resp_err_code, if0.readData);
  always @(negedge clk) if (if3.resp_valid === 1'b1) score(1, if3.resp_err, if3.resp_err_code, if3.readData);

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q3.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (exp_q0.size() != 0 || exp_q3.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d responses still outstanding, required 0", exp_q0.size(), exp_q3.size());
      exp_q0.delete(); exp_q3.delete(); cyc_q0.delete(); cyc_q3.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag, input int d);
    if (d == 0) begin
      check({tag, "_resp_valid"}, 36'(if0.resp_valid), 36'h0);
      check({tag, "_readData"}, 36'(if0.readData), 36'h0);
      check({tag, "_resp_err"}, 36'({if0.resp_err, if0.resp_err_code}), 36'h0);
      check({tag, "_state"}, 36'(dbg0), 36'(ST_IDLE));
    end else begin
      check({tag, "_resp_valid"}, 36'(if3.resp_valid), 36'h0);
      check({tag, "_readData"}, 36'(if3.readData), 36'h0);
      check({tag, "_resp_err"}, 36'({if3.resp_err, if3.resp_err_code}), 36'h0);
      check({tag, "_state"}, 36'(dbg3), 36'(ST_IDLE));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [35:0] e;
  } vec_t;
  vec_t dir [17];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 512; i++) ref_mem[d][i] = 8'h00;

    dir = '{
      '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 36'h0},
      '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        ld(32'hDEADBEEF)},
      '{1'b1, SZ_BYTE, 1'b0, 32'h11,  32'h0000007F, 36'h0},
      '{1'b0, SZ_BYTE, 1'b0, 32'h11,  32'h0,        ld(32'h0000007F)},
      '{1'b0, SZ_BYTE, 1'b1, 32'h13,  32'h0,        ld(32'h000000DE)},
      '{1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0,        ld(32'hFFFFFFDE)},
      '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        ld(32'hDEAD7FEF)},
      '{1'b0, SZ_HALF, 1'b0, 32'h12,  32'h0,        ld(32'hFFFFDEAD)},
      '{1'b0, SZ_HALF, 1'b1, 32'h12,  32'h0,        ld(32'h0000DEAD)},
      '{1'b0, SZ_HALF, 1'b0, 32'h11,  32'h0,        er(2'b01)},
      '{1'b1, SZ_WORD, 1'b0, 32'h02,  32'h11111111, er(2'b01)},
      '{1'b0, SZ_WORD, 1'b0, 32'h00,  32'h0,        ld(32'h00000000)},
      '{1'b1, SZ_WORD, 1'b0, 32'h200, 32'hCAFEF00D, er(2'b10)},
      '{1'b0, SZ_WORD, 1'b0, 32'h00,  32'h0,        ld(32'h00000000)},
      '{1'b0, SZ_RSVD, 1'b0, 32'h10,  32'h0,        er(2'b11)},
      '{1'b1, SZ_HALF, 1'b0, 32'h16,  32'h1234BEEF, 36'h0},
      '{1'b0, SZ_WORD, 1'b1, 32'h14,  32'h0,        ld(32'hBEEF0000)}
    };

    idle(0);
    idle(1);
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    #12;
    check_reset_outputs("in_reset0", 0);
    check_reset_outputs("in_reset3", 1);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset0", 36'(if0.req_ready), 36'h1);
    check("ready_after_reset3", 36'(if3.req_ready), 36'h1);

    // Directed sequences, back to back, on both instances.
    for (int d = 0; d < 2; d++) begin
      foreach (dir[i]) issue(d, dir[i].wr, dir[i].sz, dir[i].uns, dir[i].a, dir[i].wd, 1'b1, 1'b1, dir[i].e);
      idle(d);
      drain();
    end

    // Wait-state window: req_ready low for three cycles after the accept edge.
    issue(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 36'h0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      check("busy_ready_low", 36'(if3.req_ready), 36'h0);
      @(negedge clk);
    end
    check("ready_back_high", 36'(if3.req_ready), 36'h1);
    drain();

    // Randomized traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        wr  = 1'($urandom_range(0, 1));
        uns = 1'($urandom_range(0, 1));
        r   = $urandom_range(0, 9);
        sz  = (r < 9) ? 2'(r % 3) : 2'b11;
        a   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 63));
        issue(d, wr, sz, uns, a, $urandom, 1'b1, 1'b0, 36'h0);
        if ($urandom_range(0, 3) == 0) begin
          idle(d);
          @(negedge clk);
        end
      end
      idle(d);
      drain();
    end

    // Reset while a store is waiting: no write, no response, outputs cleared at once.
    issue(1, 1'b1, SZ_WORD, 1'b0, 32'h24, 32'h0BADF00D, 1'b1, 1'b0, 36'h0);
    issue(1, 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0,        1'b1, 1'b1, ld(32'h0BADF00D));
    idle(1);
    drain();
    check("readData_before_reset", 36'(if3.readData), 36'h0BADF00D);
    issue(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hA5A5A5A5, 1'b0, 1'b0, 36'h0);
    idle(1);
    check("busy_before_reset", 36'(dbg3), 36'(ST_BUSY));
    #1 rst3_n = 1'b0;
    #1 check_reset_outputs("mid_busy_reset", 1);
    repeat (3) @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    issue(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 36'h0);
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
